// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and the baud
// divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Receiver FSM state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  // Clocks per sample tick (truncated), never below 1
  function automatic int unsigned clk_div(input int unsigned clk_hz,
                                          input int unsigned baud,
                                          input int unsigned os);
    int unsigned div;
    div = clk_hz / (baud * os);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// Receiver-side signal bundle: serial line in, byte and status strobes out.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       TXD;
  logic [7:0] RX_data;
  logic       RX_valid;
  logic       RX_frame_error;
  logic       RX_busy;

  modport master (
    input  TXD,
    output RX_data,
    output RX_valid,
    output RX_frame_error,
    output RX_busy
  );

  modport slave (
    output TXD,
    input  RX_data,
    input  RX_valid,
    input  RX_frame_error,
    input  RX_busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one-clock tick every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic Clock_100MHz,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIV-1 and wrap; only Reset clears it
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_oversampler.sv
// 8N1 LSB-first UART receiver with 16x oversampling and one-cycle strobes.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit for the
// start check and every data/stop sample; otherwise a single sample is used.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE
) (
  input  logic     Clock_100MHz,
  input  logic     Reset,
  uart_rx_if.master rx
);

  localparam int unsigned TICK_DIV = clk_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned BW       = $clog2(UART_DATA_BITS);

  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  logic [1:0]                r_sync;
  logic [2:0]                r_state;
  logic [SW-1:0]             r_smp;
  logic [BW-1:0]             r_bitn;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;

  logic                      w_tick;
  logic                      w_line_s;
  logic [2:0]                w_state_next;
  logic [SW-1:0]             w_smp_next;
  logic [BW-1:0]             w_bitn_next;
  logic [UART_DATA_BITS-1:0] w_shreg_next;
  logic                      w_valid_set;
  logic                      w_ferr_set;
  logic                      w_start_abort;
  logic                      w_start_go;
  logic                      w_data_chk;
  logic                      w_data_bit;
  logic                      w_stop_chk;
  logic                      w_stop_bit;

  uart_baud_tick #(
    .DIV (TICK_DIV)
  ) u_tick (
    .Clock_100MHz (Clock_100MHz),
    .Reset        (Reset),
    .tick         (w_tick)
  );

  // Two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx.TXD};
    end
  end

  assign w_line_s = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] SMP_VLO = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] SMP_VHI = SW'(OVERSAMPLE / 2);

  logic [2:0] r_vote;
  logic       w_maj_now;
  logic       w_maj_reg;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Shift in line samples inside the mid-bit window of START/DATA/STOP
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      r_vote <= '0;
    end else if (w_tick && (r_state inside {START, DATA, STOP}) &&
                 (r_smp >= SMP_VLO) && (r_smp <= SMP_VHI)) begin
      r_vote <= {r_vote[1:0], w_line_s};
    end
  end

  // Vote including the sample being taken on the last window tick
  assign w_maj_now = maj3(r_vote[1], r_vote[0], w_line_s);
  // Vote over the completed window, used later in the bit
  assign w_maj_reg = maj3(r_vote[2], r_vote[1], r_vote[0]);

  // Counter stays bit-edge aligned: start is judged mid-bit but DATA
  // begins at the end of the start bit; STOP decides mid-bit to re-arm early
  assign w_start_abort = w_tick && (r_smp == SMP_VHI) && w_maj_now;
  assign w_start_go    = w_tick && (r_smp == SMP_LAST);
  assign w_data_chk    = w_tick && (r_smp == SMP_LAST);
  assign w_data_bit    = w_maj_reg;
  assign w_stop_chk    = w_tick && (r_smp == SMP_VHI);
  assign w_stop_bit    = w_maj_now;
`else
  // Counter restarts at mid-start, so SMP_LAST lands at each later bit's centre
  assign w_start_abort = w_tick && (r_smp == SMP_MID) && w_line_s;
  assign w_start_go    = w_tick && (r_smp == SMP_MID) && !w_line_s;
  assign w_data_chk    = w_tick && (r_smp == SMP_LAST);
  assign w_data_bit    = w_line_s;
  assign w_stop_chk    = w_tick && (r_smp == SMP_LAST);
  assign w_stop_bit    = w_line_s;
`endif

  // FSM state register
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_tick && !w_line_s) w_state_next = START;
      START: begin
        if (w_start_abort) begin
          w_state_next = IDLE;
        end else if (w_start_go) begin
          w_state_next = DATA;
        end
      end
      DATA:  if (w_data_chk && (r_bitn == BIT_LAST)) w_state_next = STOP;
      STOP:  if (w_stop_chk) w_state_next = w_stop_bit ? IDLE : BREAK;
      // Wait for the line to return high so a held-low line cannot restart
      BREAK: if (w_tick && w_line_s) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: counter/shift-register updates and strobe requests
  always_comb begin
    w_smp_next   = r_smp;
    w_bitn_next  = r_bitn;
    w_shreg_next = r_shreg;
    w_valid_set  = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      IDLE: w_smp_next = '0;
      START: begin
        if (w_tick) w_smp_next = w_start_go ? '0 : r_smp + 1'b1;
        if (w_start_go) w_bitn_next = '0;
      end
      DATA: begin
        if (w_tick) w_smp_next = r_smp + 1'b1;
        if (w_data_chk) begin
          w_shreg_next = {w_data_bit, r_shreg[UART_DATA_BITS-1:1]};
          w_bitn_next  = r_bitn + 1'b1;
        end
      end
      STOP: begin
        if (w_tick) w_smp_next = r_smp + 1'b1;
        if (w_stop_chk) begin
          w_valid_set = w_stop_bit;
          w_ferr_set  = !w_stop_bit;
        end
      end
      default: w_smp_next = '0;
    endcase
  end

  // Datapath and registered output strobes
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      r_smp   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_smp   <= w_smp_next;
      r_bitn  <= w_bitn_next;
      r_shreg <= w_shreg_next;
      r_valid <= w_valid_set;
      r_ferr  <= w_ferr_set;
      if (w_valid_set) r_data <= r_shreg;
    end
  end

  assign rx.RX_data        = r_data;
  assign rx.RX_valid       = r_valid;
  assign rx.RX_frame_error = r_ferr;
  assign rx.RX_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed frame table, random frames against a
// frame-level model, and hand sequences for glitch, break, reset and spikes.
module tb_uart_rx_oversampler;

  localparam int unsigned CLK_HZ = 640_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int unsigned OS     = 16;
  localparam int          TICK   = CLK_HZ / (BAUD * OS);
  localparam int          BIT    = OS * TICK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if u_if ();

  uart_rx_oversampler #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLE  (OS)
  ) dut (
    .Clock_100MHz (clk),
    .Reset        (rst),
    .rx           (u_if)
  );

  always #5 clk = ~clk;

  // kind: 1 = valid, 2 = frame error, 3 = both strobes together
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  ev_t ev_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  // Record every strobe away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!rst && (u_if.RX_valid || u_if.RX_frame_error)) begin
      ev_t e;
      e.kind = (u_if.RX_valid && u_if.RX_frame_error) ? 3 : (u_if.RX_valid ? 1 : 2);
      e.data = u_if.RX_data;
      e.cyc  = cyc;
      ev_q.push_back(e);
    end
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit v);
    u_if.TXD = v;
    wait_clks(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int gap_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    for (int g = 0; g < gap_bits; g++) drive_bit(1'b1);
  endtask

  task automatic expect_event(input string name, input int kind, input logic [7:0] d,
                              output int ecyc);
    ev_t e;
    ecyc = 0;
    if (ev_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no strobe, required kind %0d data %0h", name, kind, d);
    end else begin
      e    = ev_q.pop_front();
      ecyc = e.cyc;
      chk({name, " kind"}, e.kind, kind);
      chk({name, " data"}, e.data, d);
    end
  endtask

  task automatic expect_none(input string name);
    chk(name, ev_q.size(), 0);
    ev_q.delete();
  endtask

  vec_t       tbl [6];
  logic [7:0] last_good;
  int         ecyc;
  int         prev_cyc;

  initial begin
    tbl[0] = '{data: 8'hA5, stop: 1'b1, gap: 1, exp_kind: 1, exp_data: 8'hA5};
    tbl[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_kind: 1, exp_data: 8'h00};
    tbl[2] = '{data: 8'hFF, stop: 1'b1, gap: 1, exp_kind: 1, exp_data: 8'hFF};
    tbl[3] = '{data: 8'h3C, stop: 1'b0, gap: 2, exp_kind: 2, exp_data: 8'hFF};
    tbl[4] = '{data: 8'h5A, stop: 1'b1, gap: 1, exp_kind: 1, exp_data: 8'h5A};
    tbl[5] = '{data: 8'h81, stop: 1'b1, gap: 1, exp_kind: 1, exp_data: 8'h81};

    u_if.TXD = 1'b1;
    rst      = 1'b1;
    wait_clks(3);
    chk("reset RX_data", u_if.RX_data, 8'h00);
    chk("reset RX_valid", u_if.RX_valid, 1'b0);
    chk("reset RX_frame_error", u_if.RX_frame_error, 1'b0);
    chk("reset RX_busy", u_if.RX_busy, 1'b0);
    rst = 1'b0;
    wait_clks(2 * BIT);

    // Directed frame table; entry 2 follows entry 1 with no idle gap
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap);
      expect_event($sformatf("table[%0d]", i), tbl[i].exp_kind, tbl[i].exp_data, ecyc);
      if (i > 0 && tbl[i-1].gap == 0) begin
        chk($sformatf("table[%0d] b2b spacing ok", i),
            ((ecyc - prev_cyc) >= 10 * BIT - 2 * TICK) &&
            ((ecyc - prev_cyc) <= 10 * BIT + 2 * TICK), 1'b1);
      end
      prev_cyc = ecyc;
    end
    expect_none("table extra strobes");
    last_good = 8'h81;

    // Random frames against a frame-level model
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      bit         stop;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 6) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : 2;
      send_frame(d, stop, gap);
      if (stop) begin
        expect_event($sformatf("rand[%0d] valid", n), 1, d, ecyc);
        last_good = d;
      end else begin
        expect_event($sformatf("rand[%0d] ferr", n), 2, last_good, ecyc);
      end
    end
    wait_clks(BIT);
    expect_none("rand extra strobes");

    // Short low glitch: start rejected mid-bit
    u_if.TXD = 1'b0;
    wait_clks(3 * TICK);
    chk("glitch busy rises", u_if.RX_busy, 1'b1);
    wait_clks(TICK);
    u_if.TXD = 1'b1;
    wait_clks(BIT - 4 * TICK);
    chk("glitch busy low within 1 bit", u_if.RX_busy, 1'b0);
    wait_clks(2 * BIT);
    expect_none("glitch no strobe");

    // Bad stop bit then line held low: one error, no restart until release
    send_frame(8'h3C, 1'b0, 0);
    u_if.TXD = 1'b0;
    wait_clks(20 * BIT);
    chk("break busy held", u_if.RX_busy, 1'b1);
    expect_event("break ferr", 2, last_good, ecyc);
    expect_none("break single strobe");
    u_if.TXD = 1'b1;
    wait_clks(2 * BIT);
    chk("break released busy", u_if.RX_busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1);
    expect_event("after break", 1, 8'h5A, ecyc);
    last_good = 8'h5A;

    // Reset during data bit 4 of 8'hC3; the host abandons that frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'hC3 >> i) & 8'h01));
    u_if.TXD = 1'b0;
    wait_clks(BIT / 2);
    rst      = 1'b1;
    u_if.TXD = 1'b1;
    wait_clks(1);
    chk("midreset RX_data", u_if.RX_data, 8'h00);
    chk("midreset RX_valid", u_if.RX_valid, 1'b0);
    chk("midreset RX_busy", u_if.RX_busy, 1'b0);
    rst = 1'b0;
    wait_clks(12 * BIT);
    chk("midreset data held 0", u_if.RX_data, 8'h00);
    expect_none("midreset no strobe");
    send_frame(8'h81, 1'b1, 1);
    expect_event("after reset", 1, 8'h81, ecyc);
    last_good = 8'h81;

    // One-clock low spike at the centre of every data bit of 8'hFF
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      u_if.TXD = 1'b1;
      wait_clks(BIT / 2);
      u_if.TXD = 1'b0;
      wait_clks(1);
      u_if.TXD = 1'b1;
      wait_clks(BIT / 2 - 1);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
`ifdef UART_RX_MAJORITY_EN
    expect_event("spike majority", 1, 8'hFF, ecyc);
`else
    if (ev_q.size() == 0) begin
      $display("note: spiked 8'hFF without majority vote gave no strobe");
    end else begin
      $display("note: spiked 8'hFF without majority vote gave kind %0d data %0h",
               ev_q[0].kind, ev_q[0].data);
    end
    ev_q.delete();
`endif
    wait_clks(2 * BIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
